// File: rtl/uart_pkg.sv
// Shared constants for the UART tx scheduler: FSM encoding, ASCII bytes and report lengths.
package uart_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam logic [3:0] RPT_LEN_PLAIN = 4'd11;
  localparam logic [3:0] RPT_LEN_CRLF  = 4'd13;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Byte handshake between the scheduler (master) and the UART transmitter (slave).
interface uart_tx_scheduler_if;

  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;

  modport master (output tx_data, output tx_start, input tx_busy, input tx_done);
  modport slave  (input tx_data, input tx_start, output tx_busy, output tx_done);

endinterface

// File: rtl/bin2dec2.sv
// Combinational 7-bit binary to two ASCII decimal digits, clamped to FIELD_MAX.
module bin2dec2 #(
  parameter int unsigned FIELD_MAX = 99
) (
  input  logic [6:0] i_val,
  output logic [7:0] o_tens,
  output logic [7:0] o_ones
);
  import uart_pkg::*;

  localparam logic [6:0] MAX7 = 7'(FIELD_MAX);

  logic [6:0] w_clamp;
  logic [6:0] w_tens;
  logic [6:0] w_ones;

  always_comb begin
    w_clamp = (i_val > MAX7) ? MAX7 : i_val;
    w_tens  = w_clamp / 7'd10;
    w_ones  = w_clamp % 7'd10;
    o_tens  = ASCII_ZERO + {1'b0, w_tens};
    o_ones  = ASCII_ZERO + {1'b0, w_ones};
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART tx between the echo path and an HH:MM:SS.CC time report (echo has priority).
// Define UART_TX_SCHED_CRLF_EN to append CR/LF to every report.
module uart_tx_scheduler #(
  parameter int unsigned FIELD_MAX = 99
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        echo_req,
  input  logic [7:0]                  echo_data,
  output logic                        echo_drop,
  input  logic                        rpt_req,
  input  logic [4:0]                  hour,
  input  logic [5:0]                  min,
  input  logic [5:0]                  sec,
  input  logic [6:0]                  csec,
  output logic                        rpt_busy,
  uart_tx_scheduler_if.master         tx
);
  import uart_pkg::*;

`ifdef UART_TX_SCHED_CRLF_EN
  localparam bit CRLF_EN = 1'b1;
`else
  localparam bit CRLF_EN = 1'b0;
`endif
  localparam logic [3:0] RPT_LEN = CRLF_EN ? RPT_LEN_CRLF : RPT_LEN_PLAIN;

  logic [0:0]      r_state;
  logic            r_src_echo;
  logic            r_pend;
  logic [7:0]      r_echo_byte;
  logic            r_rpt_busy;
  logic [3:0]      r_idx;
  logic [7:0][7:0] r_dig;
  logic [7:0]      r_tx_data;
  logic            r_echo_drop;

  logic [7:0][7:0] w_dig;
  logic [7:0]      w_rpt_byte;
  logic [7:0]      w_byte;
  logic            w_launch;
  logic            w_launch_echo;
  logic            w_rpt_last;

  bin2dec2 #(.FIELD_MAX(FIELD_MAX)) u_hour (.i_val({2'b00, hour}), .o_tens(w_dig[0]), .o_ones(w_dig[1]));
  bin2dec2 #(.FIELD_MAX(FIELD_MAX)) u_min  (.i_val({1'b0, min}),   .o_tens(w_dig[2]), .o_ones(w_dig[3]));
  bin2dec2 #(.FIELD_MAX(FIELD_MAX)) u_sec  (.i_val({1'b0, sec}),   .o_tens(w_dig[4]), .o_ones(w_dig[5]));
  bin2dec2 #(.FIELD_MAX(FIELD_MAX)) u_csec (.i_val(csec),          .o_tens(w_dig[6]), .o_ones(w_dig[7]));

  always_comb begin
    w_rpt_byte = ASCII_LF;
    case (r_idx)
      4'd0:    w_rpt_byte = r_dig[0];
      4'd1:    w_rpt_byte = r_dig[1];
      4'd2:    w_rpt_byte = ASCII_COLON;
      4'd3:    w_rpt_byte = r_dig[2];
      4'd4:    w_rpt_byte = r_dig[3];
      4'd5:    w_rpt_byte = ASCII_COLON;
      4'd6:    w_rpt_byte = r_dig[4];
      4'd7:    w_rpt_byte = r_dig[5];
      4'd8:    w_rpt_byte = ASCII_DOT;
      4'd9:    w_rpt_byte = r_dig[6];
      4'd10:   w_rpt_byte = r_dig[7];
      4'd11:   w_rpt_byte = ASCII_CR;
      default: w_rpt_byte = ASCII_LF;
    endcase
  end

  always_comb begin
    w_launch      = (r_state == ST_IDLE) && !tx.tx_busy && (r_pend || r_rpt_busy);
    w_launch_echo = w_launch && r_pend;
    w_byte        = r_pend ? r_echo_byte : w_rpt_byte;
    w_rpt_last    = (r_idx == RPT_LEN - 4'd1);
  end

  // Start is decoded combinationally so a request reaches the tx one cycle later.
  assign tx.tx_start = w_launch;
  assign tx.tx_data  = w_launch ? w_byte : r_tx_data;
  assign echo_drop   = r_echo_drop;
  assign rpt_busy    = r_rpt_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_src_echo  <= 1'b0;
      r_pend      <= 1'b0;
      r_echo_byte <= '0;
      r_rpt_busy  <= 1'b0;
      r_idx       <= '0;
      r_dig       <= '0;
      r_tx_data   <= '0;
      r_echo_drop <= 1'b0;
    end else begin
      r_echo_drop <= echo_req && r_pend && !w_launch_echo;

      // The in-flight echo byte lives in r_tx_data, so pend frees up at launch
      // and a new echo arriving during WAIT is held rather than lost.
      if (echo_req) begin
        r_pend      <= 1'b1;
        r_echo_byte <= echo_data;
      end else if (w_launch_echo) begin
        r_pend <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_tx_data  <= w_byte;
            r_src_echo <= r_pend;
            r_state    <= ST_WAIT;
          end
        end
        default: begin
          if (tx.tx_done) begin
            r_state <= ST_IDLE;
            if (!r_src_echo) begin
              if (w_rpt_last) r_rpt_busy <= 1'b0;
              else            r_idx      <= r_idx + 4'd1;
            end
          end
        end
      endcase

      if (rpt_req && !r_rpt_busy) begin
        r_rpt_busy <= 1'b1;
        r_idx      <= '0;
        r_dig      <= w_dig;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: echo, report text, interleave, overflow, clamp, reset.
module tb_uart_tx_scheduler;

`ifdef UART_TX_SCHED_CRLF_EN
  localparam int unsigned RPT_N = 13;
`else
  localparam int unsigned RPT_N = 11;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       echo_req;
  logic [7:0] echo_data;
  logic       echo_drop;
  logic       rpt_req;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [6:0] csec;
  logic       rpt_busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned drops;
  int unsigned starts;
  logic [7:0]  exp_b [13];

  uart_tx_scheduler_if u_if ();

  uart_tx_scheduler #(.FIELD_MAX(99)) dut (
    .clk       (clk),
    .reset     (reset),
    .echo_req  (echo_req),
    .echo_data (echo_data),
    .echo_drop (echo_drop),
    .rpt_req   (rpt_req),
    .hour      (hour),
    .min       (min),
    .sec       (sec),
    .csec      (csec),
    .rpt_busy  (rpt_busy),
    .tx        (u_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic finish_byte(input bit inj, input logic [7:0] d);
    u_if.tx_busy = 1'b1;
    if (inj) begin
      echo_req  = 1'b1;
      echo_data = d;
    end
    tick;
    echo_req = 1'b0;
    tick;
    u_if.tx_busy = 1'b0;
    u_if.tx_done = 1'b1;
    tick;
    u_if.tx_done = 1'b0;
  endtask

  task automatic xfer(input string tag, input logic [7:0] exp, input bit inj, input logic [7:0] d);
    int unsigned k = 0;
    #1;
    while (!u_if.tx_start && k < 40) begin
      tick;
      k++;
    end
    if (!u_if.tx_start) begin
      check({tag, "_timeout"}, 32'(u_if.tx_start), 32'd1);
      return;
    end
    check(tag, 32'(u_if.tx_data), 32'(exp));
    tick;
    check({tag, "_pulse"}, 32'(u_if.tx_start), 32'd0);
    finish_byte(inj, d);
  endtask

  task automatic count_starts(input int unsigned cycles);
    starts = 0;
    repeat (cycles) begin
      tick;
      if (u_if.tx_start) starts++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; echo_req = 1'b0; echo_data = '0; rpt_req = 1'b0;
    hour = '0; min = '0; sec = '0; csec = '0;
    u_if.tx_busy = 1'b0; u_if.tx_done = 1'b0;
    tick; tick;
    check("rst_start", 32'(u_if.tx_start), 32'd0);
    check("rst_data",  32'(u_if.tx_data),  32'h00);
    check("rst_drop",  32'(echo_drop),     32'd0);
    check("rst_busy",  32'(rpt_busy),      32'd0);
    reset = 1'b0;
    tick;

    // Echo with one-cycle latency, then idle again
    echo_data = 8'h72; echo_req = 1'b1;
    tick;
    echo_req = 1'b0;
    check("echo_lat", 32'(u_if.tx_start), 32'd1);
    xfer("echo_r", 8'h72, 1'b0, 8'h00);
    count_starts(3);
    check("echo_idle", starts, 32'd0);
    echo_data = 8'h5A; echo_req = 1'b1;
    tick;
    echo_req = 1'b0;
    check("echo2_lat", 32'(u_if.tx_start), 32'd1);
    xfer("echo_Z", 8'h5A, 1'b0, 8'h00);

    // Report 07:05:59.03, inputs changed after acceptance
    exp_b = '{8'h30, 8'h37, 8'h3A, 8'h30, 8'h35, 8'h3A, 8'h35, 8'h39, 8'h2E, 8'h30, 8'h33, 8'h0D, 8'h0A};
    hour = 5'd7; min = 6'd5; sec = 6'd59; csec = 7'd3;
    rpt_req = 1'b1;
    tick;
    rpt_req = 1'b0;
    hour = 5'd23; min = 6'd48; sec = 6'd1; csec = 7'd66;
    check("rpt_accept", 32'(rpt_busy), 32'd1);
    check("rpt_lat", 32'(u_if.tx_start), 32'd1);
    for (int unsigned i = 0; i < RPT_N; i++) begin
      if (i == RPT_N - 1) check("rpt_busy_last", 32'(rpt_busy), 32'd1);
      xfer($sformatf("rpt%0d", i), exp_b[i], 1'b0, 8'h00);
    end
    check("rpt_busy_end", 32'(rpt_busy), 32'd0);

    // Echo 'X' arrives while report byte index 2 is shifting
    hour = 5'd7; min = 6'd5; sec = 6'd59; csec = 7'd3;
    rpt_req = 1'b1;
    tick;
    rpt_req = 1'b0;
    for (int unsigned i = 0; i < 3; i++)
      xfer($sformatf("ilv%0d", i), exp_b[i], i == 2, 8'h58);
    xfer("ilv_X", 8'h58, 1'b0, 8'h00);
    for (int unsigned i = 3; i < RPT_N; i++)
      xfer($sformatf("ilv%0d", i), exp_b[i], 1'b0, 8'h00);
    check("ilv_busy_end", 32'(rpt_busy), 32'd0);

    // Overflow: 'a' then 'b' while the tx is busy
    u_if.tx_busy = 1'b1;
    drops = 0;
    echo_data = 8'h61; echo_req = 1'b1;
    tick;
    drops += 32'(echo_drop);
    echo_data = 8'h62;
    tick;
    drops += 32'(echo_drop);
    echo_req = 1'b0;
    check("ovf_nostart", 32'(u_if.tx_start), 32'd0);
    repeat (2) begin
      tick;
      drops += 32'(echo_drop);
    end
    check("ovf_drops", drops, 32'd1);
    u_if.tx_busy = 1'b0;
    xfer("ovf_b", 8'h62, 1'b0, 8'h00);
    count_starts(8);
    check("ovf_no_a", starts, 32'd0);

    // New echo in the same cycle the pending echo launches
    u_if.tx_busy = 1'b1;
    echo_data = 8'h70; echo_req = 1'b1;
    tick;
    echo_req = 1'b0;
    u_if.tx_busy = 1'b0;
    echo_data = 8'h71; echo_req = 1'b1;
    #1;
    check("co_start", 32'(u_if.tx_start), 32'd1);
    check("co_data",  32'(u_if.tx_data),  32'h70);
    tick;
    echo_req = 1'b0;
    check("co_nodrop", 32'(echo_drop), 32'd0);
    finish_byte(1'b0, 8'h00);
    xfer("co_q", 8'h71, 1'b0, 8'h00);

    // Clamp 31:63:42.127 -> 31:63:42.99, plus a request ignored while busy
    exp_b = '{8'h33, 8'h31, 8'h3A, 8'h36, 8'h33, 8'h3A, 8'h34, 8'h32, 8'h2E, 8'h39, 8'h39, 8'h0D, 8'h0A};
    hour = 5'd31; min = 6'd63; sec = 6'd42; csec = 7'd127;
    rpt_req = 1'b1;
    tick;
    rpt_req = 1'b0;
    for (int unsigned i = 0; i < RPT_N; i++) begin
      rpt_req = (i == 2);
      xfer($sformatf("clamp%0d", i), exp_b[i], 1'b0, 8'h00);
    end
    rpt_req = 1'b0;
    check("clamp_busy_end", 32'(rpt_busy), 32'd0);
    count_starts(10);
    check("clamp_no_extra", starts, 32'd0);

    // Reset while report byte index 4 is in flight with an echo pending
    exp_b = '{8'h30, 8'h37, 8'h3A, 8'h30, 8'h35, 8'h3A, 8'h35, 8'h39, 8'h2E, 8'h30, 8'h33, 8'h0D, 8'h0A};
    hour = 5'd7; min = 6'd5; sec = 6'd59; csec = 7'd3;
    rpt_req = 1'b1;
    tick;
    rpt_req = 1'b0;
    for (int unsigned i = 0; i < 4; i++)
      xfer($sformatf("mid%0d", i), exp_b[i], 1'b0, 8'h00);
    #1;
    check("mid_start4", 32'(u_if.tx_start), 32'd1);
    tick;
    u_if.tx_busy = 1'b1;
    echo_data = 8'h41; echo_req = 1'b1;
    tick;
    echo_req = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("mrst_start", 32'(u_if.tx_start), 32'd0);
    check("mrst_data",  32'(u_if.tx_data),  32'h00);
    check("mrst_drop",  32'(echo_drop),     32'd0);
    check("mrst_busy",  32'(rpt_busy),      32'd0);
    u_if.tx_busy = 1'b0;
    u_if.tx_done = 1'b1;
    #1;
    check("stray_done_start", 32'(u_if.tx_start), 32'd0);
    tick;
    u_if.tx_done = 1'b0;
    count_starts(10);
    check("stray_no_start", starts, 32'd0);

    echo_data = 8'h6B; echo_req = 1'b1;
    tick;
    echo_req = 1'b0;
    check("post_rst_lat", 32'(u_if.tx_start), 32'd1);
    xfer("post_rst_k", 8'h6B, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
